// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: states, opcodes,
// datapath select codes and the packed control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StRst     = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StRtypeEx = 4'd7,
    StRtypeWb = 4'd8,
    StBeqEx   = 4'd9,
    StJump    = 4'd10,
    StAddiEx  = 4'd11,
    StAddiWb  = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [1:0] PcSrcAluResult = 2'd0;
  localparam logic [1:0] PcSrcAluOut    = 2'd1;
  localparam logic [1:0] PcSrcJump      = 2'd2;

  localparam logic [1:0] AluBReg        = 2'd0;
  localparam logic [1:0] AluBFour       = 2'd1;
  localparam logic [1:0] AluBSignExt    = 2'd2;
  localparam logic [1:0] AluBSignExtSh2 = 2'd3;

  localparam logic [1:0] AluOpAdd   = 2'd0;
  localparam logic [1:0] AluOpSub   = 2'd1;
  localparam logic [1:0] AluOpFunct = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OpRtype) || (op == OpLw) || (op == OpSw) ||
           (op == OpBeq) || (op == OpJ) || (op == OpAddi);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decode: registered state (plus MemReady in FETCH) to control word.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = AluBFour;
        ctrl.alu_op    = AluOpAdd;
        ctrl.pc_source = PcSrcAluResult;
        // IR and PC only load once the instruction word has actually arrived
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b = AluBSignExtSh2;
        ctrl.alu_op    = AluOpAdd;
      end
      StMemAdr, StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = AluBSignExt;
        ctrl.alu_op    = AluOpAdd;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      StRtypeEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = AluBReg;
        ctrl.alu_op    = AluOpFunct;
      end
      StRtypeWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      StBeqEx: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = AluBReg;
        ctrl.alu_op        = AluOpSub;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PcSrcAluOut;
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PcSrcJump;
      end
      StAddiWb: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control: state register, next-state logic and the
// registered illegal-opcode pulse; outputs come from ctrl_decode.
module main_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PC_Source,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] State,
  output logic       IllegalOp
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl;

  // Branch qualification with Zero happens in the datapath.
  logic unused_zero;
  assign unused_zero = Zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRst;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = StRst;
    illegal_d = 1'b0;
    case (state_q)
      StRst:   state_d = StFetch;
      StFetch: state_d = MemReady ? StDecode : StFetch;
      StDecode: begin
        if (Opcode == OpRtype) begin
          state_d = StRtypeEx;
        end else if (Opcode == OpLw || Opcode == OpSw) begin
          state_d = StMemAdr;
        end else if (Opcode == OpBeq) begin
          state_d = StBeqEx;
        end else if (Opcode == OpJ) begin
          state_d = StJump;
        end else if (Opcode == OpAddi) begin
          state_d = StAddiEx;
        end else begin
          state_d = StFetch;
        end
        illegal_d = !is_legal_op(Opcode);
      end
      StMemAdr:  state_d = (Opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:   state_d = MemReady ? StMemWb : StMemRd;
      StMemWb:   state_d = StFetch;
      StMemWr:   state_d = MemReady ? StFetch : StMemWr;
      StRtypeEx: state_d = StRtypeWb;
      StRtypeWb: state_d = StFetch;
      StBeqEx:   state_d = StFetch;
      StJump:    state_d = StFetch;
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      // Corrupted encodings recover through RST.
      default:   state_d = StRst;
    endcase
  end

  ctrl_decode u_ctrl_decode (
    .state     (state_q),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign PC_Source   = ctrl.pc_source;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign State       = state_q;
  assign IllegalOp   = illegal_q;

endmodule
